// File: rtl/wb_host_bridge_pkg.sv
// Shared types and constants for the Wishbone host bridge.
// Contents: FSM state enum, retry limit, bus widths, response payload struct.
package wb_host_bridge_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned SEL_WIDTH   = 4;
    localparam int unsigned MAX_RETRY   = 3;
    localparam int unsigned RETRY_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
        logic                  err;
        logic                  tmo;
    } rsp_t;

endpackage

// File: rtl/wb_host_bridge_tmo.sv
// Watchdog counter: cleared by load, counts up while en, flags when it hits LIMIT.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   load       - clear the count to zero
//   en         - count one cycle
//   expired_c  - combinational flag, count equals LIMIT
module wb_host_bridge_tmo #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned LIMIT     = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired_c
);

    logic [CNT_WIDTH-1:0] cnt;

    // Load takes priority so a new access always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign expired_c = (cnt == CNT_WIDTH'(LIMIT));

endmodule

// File: rtl/wb_host_bridge.sv
// Wishbone pipelined master: turns one host valid/ready request into a single
// Wishbone cycle and always returns a response (ack, err/rty, or timeout).
// Optional macro WB_HOST_BRIDGE_RETRY_EN: rty re-issues the access up to
// MAX_RETRY times before reporting err; without it rty reports err at once.
// Ports:
//   clk_i, rst_i                      - clock, asynchronous active-high reset
//   req_valid_i/req_ready_o           - host request handshake
//   req_we_i, req_adr_i, req_sel_i, req_dat_i - request payload
//   rsp_valid_o/rsp_ready_i           - host response handshake
//   rsp_dat_o, rsp_err_o, rsp_tmo_o   - response payload
//   wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o - Wishbone master out
//   wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i       - Wishbone master in
module wb_host_bridge
    import wb_host_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_adr_i,
    input  logic [SEL_WIDTH-1:0]  req_sel_i,
    input  logic [DATA_WIDTH-1:0] req_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  rsp_tmo_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [SEL_WIDTH-1:0]  wb_sel_o,
    output logic                  wb_we_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic                  wb_stall_i
);

    state_t state, state_next;
    rsp_t   rsp_q, rsp_next;
    logic   rsp_load;
    logic   accept;
    logic   busy;
    logic   expired_c;
    logic   retry_c;
    logic   rty_fail_c;

    assign accept = (state == IDLE) && req_valid_i && req_ready_o;
    assign busy   = (state == STROBE) || (state == WAIT);

    // Watchdog runs across retries; only a new request clears it.
    wb_host_bridge_tmo #(
        .CNT_WIDTH(CNT_WIDTH),
        .LIMIT    (TIMEOUT)
    ) u_tmo (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (accept),
        .en       (busy),
        .expired_c(expired_c)
    );

`ifdef WB_HOST_BRIDGE_RETRY_EN
    logic [RETRY_WIDTH-1:0] retry_cnt;

    // err outranks rty, so an rty alongside err never consumes a retry.
    assign retry_c = wb_rty_i && !wb_err_i && (retry_cnt < RETRY_WIDTH'(MAX_RETRY));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retry_cnt <= '0;
        end else if (state == IDLE) begin
            retry_cnt <= '0;
        end else if (busy && retry_c) begin
            retry_cnt <= retry_cnt + RETRY_WIDTH'(1);
        end
    end
`else
    assign retry_c = 1'b0;
`endif

    assign rty_fail_c = wb_rty_i && !retry_c;

    // Next state and response payload; terminations ranked err > rty > ack > timeout.
    always_comb begin
        state_next = state;
        rsp_next   = '0;
        rsp_load   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = STROBE;
                end
            end
            STROBE, WAIT: begin
                if (wb_err_i || rty_fail_c) begin
                    state_next   = RESP;
                    rsp_load     = 1'b1;
                    rsp_next.err = 1'b1;
                end else if (retry_c) begin
                    state_next = STROBE;
                end else if (wb_ack_i) begin
                    state_next   = RESP;
                    rsp_load     = 1'b1;
                    rsp_next.dat = wb_we_o ? '0 : wb_dat_i;
                end else if (expired_c) begin
                    state_next   = RESP;
                    rsp_load     = 1'b1;
                    rsp_next.err = 1'b1;
                    rsp_next.tmo = 1'b1;
                end else if ((state == STROBE) && !wb_stall_i) begin
                    state_next = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State plus registered outputs decoded from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_adr_o    <= '0;
            wb_sel_o    <= '0;
            wb_we_o     <= 1'b0;
            wb_dat_o    <= '0;
            rsp_q       <= '0;
        end else begin
            state       <= state_next;
            req_ready_o <= (state_next == IDLE);
            rsp_valid_o <= (state_next == RESP);
            wb_cyc_o    <= (state_next == STROBE) || (state_next == WAIT);
            wb_stb_o    <= (state_next == STROBE);
            if (accept) begin
                wb_adr_o <= req_adr_i & ~ADDR_WIDTH'(3);
                wb_sel_o <= req_sel_i;
                wb_we_o  <= req_we_i;
                wb_dat_o <= req_dat_i;
            end
            if (rsp_load) begin
                rsp_q <= rsp_next;
            end
        end
    end

    assign rsp_dat_o = rsp_q.dat;
    assign rsp_err_o = rsp_q.err;
    assign rsp_tmo_o = rsp_q.tmo;

endmodule

// File: tb/tb_wb_host_bridge.sv
// Self-checking bench for wb_host_bridge: directed cases plus randomized
// transactions whose outcome is predicted from the bridge's rules
// (termination time, priorities, timeout) with plain arithmetic.
module tb_wb_host_bridge;

    localparam int unsigned AW  = 4;
    localparam int          TMO = 4;
    localparam int          RETRY_LIMIT = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i, req_ready_o, req_we_i;
    logic [AW-1:0] req_adr_i;
    logic [3:0]    req_sel_i;
    logic [31:0]   req_dat_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_tmo_o;
    logic [31:0]   rsp_dat_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [3:0]    wb_sel_o;
    logic [31:0]   wb_dat_o, wb_dat_i;
    logic          wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;

    int n_checks = 0;
    int n_errors = 0;

    wb_host_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TMO), .CNT_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_adr_i(req_adr_i), .req_sel_i(req_sel_i), .req_dat_i(req_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .rsp_tmo_o(rsp_tmo_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic slave_idle();
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        wb_rty_i   = 1'b0;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!req_ready_o && k < 20) begin
            step();
            k++;
        end
        check("req_ready", 32'(req_ready_o), 32'd1);
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [3:0] sel,
                         input logic [31:0] wdat);
        wait_ready();
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_adr_i   = adr;
        req_sel_i   = sel;
        req_dat_i   = wdat;
        step();
        req_valid_i = 1'b0;
        check("cyc_stb_rise", 32'({wb_cyc_o, wb_stb_o}), 32'd3);
        check("wb_adr", 32'(wb_adr_o), 32'(adr) & 32'hFFFF_FFFC);
        check("wb_dat", wb_dat_o, wdat);
        check("wb_sel_we", 32'({wb_sel_o, wb_we_o}), 32'({sel, we}));
    endtask

    task automatic handshake();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check("rsp_consumed", 32'(rsp_valid_o), 32'd0);
        check("ready_after_rsp", 32'(req_ready_o), 32'd1);
    endtask

    // kind: 0 ack, 1 err, 2 rty, 3 err+ack, 4 no answer
    task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [3:0] sel,
                           input logic [31:0] wdat, input logic [31:0] rdat,
                           input int stall_n, input int term_at, input int kind_in,
                           input int hold, input bit pend);
        int k, kind, stb_n, iss_n, cyc_n, exp_end;
        bit timed, exp_err;
        logic [31:0] exp_dat;
        kind = kind_in;
`ifdef WB_HOST_BRIDGE_RETRY_EN
        if (kind == 2) kind = 1;
`endif
        timed   = (kind == 4) || (term_at > TMO);
        exp_end = timed ? TMO : term_at;
        exp_err = timed || (kind != 0);
        exp_dat = (!exp_err && !we) ? rdat : 32'd0;

        issue(we, adr, sel, wdat);
        k = 0; stb_n = 0; iss_n = 0; cyc_n = 0;
        while (!rsp_valid_o && k < 3 * TMO + 8) begin
            wb_stall_i = (k < stall_n);
            wb_ack_i   = (k == term_at) && (kind == 0 || kind == 3);
            wb_err_i   = (k == term_at) && (kind == 1 || kind == 3);
            wb_rty_i   = (k == term_at) && (kind == 2);
            wb_dat_i   = (k == term_at) ? rdat : $urandom;
            if (wb_stb_o) stb_n++;
            if (wb_stb_o && !wb_stall_i) iss_n++;
            if (wb_cyc_o) cyc_n++;
            step();
            k++;
        end
        slave_idle();
        check("rsp_latency", 32'(k), 32'(exp_end + 1));
        check("cyc_cycles", 32'(cyc_n), 32'(exp_end + 1));
        check("stb_cycles", 32'(stb_n), 32'(((stall_n < exp_end) ? stall_n : exp_end) + 1));
        check("strobes_issued", 32'(iss_n), (stall_n <= exp_end) ? 32'd1 : 32'd0);
        check("cyc_low_at_rsp", 32'({wb_cyc_o, wb_stb_o}), 32'd0);
        check("rsp_err_tmo", 32'({rsp_err_o, rsp_tmo_o}), 32'({exp_err, timed}));
        check("rsp_dat", rsp_dat_o, exp_dat);

        if (pend) begin
            req_valid_i = 1'b1;
            req_adr_i   = AW'($urandom);
        end
        for (int i = 0; i < hold; i++) begin
            wb_ack_i = 1'($urandom);
            wb_err_i = 1'($urandom);
            wb_rty_i = 1'($urandom);
            step();
            check("hold_valid", 32'(rsp_valid_o), 32'd1);
            check("hold_fields", 32'({rsp_err_o, rsp_tmo_o, wb_cyc_o}), 32'({exp_err, timed, 1'b0}));
            check("hold_dat", rsp_dat_o, exp_dat);
            check("hold_req_blocked", 32'(req_ready_o), 32'd0);
        end
        slave_idle();
        handshake();
        req_valid_i = 1'b0;
    endtask

`ifdef WB_HOST_BRIDGE_RETRY_EN
    task automatic retry_txn(input int n_rty, input logic [31:0] rdat);
        int k, stb_n;
        bit ok;
        ok = (n_rty <= RETRY_LIMIT);
        issue(1'b0, AW'(4), 4'hF, 32'd0);
        k = 0; stb_n = 0;
        while (!rsp_valid_o && k < 20) begin
            wb_stall_i = 1'b0;
            wb_rty_i   = (k < n_rty);
            wb_ack_i   = (k == n_rty);
            wb_dat_i   = rdat;
            if (wb_stb_o) stb_n++;
            step();
            k++;
        end
        slave_idle();
        check("retry_strobes", 32'(stb_n), ok ? 32'(n_rty + 1) : 32'(RETRY_LIMIT + 1));
        check("retry_err_tmo", 32'({rsp_err_o, rsp_tmo_o}), ok ? 32'd0 : 32'd2);
        check("retry_dat", rsp_dat_o, ok ? rdat : 32'd0);
        handshake();
    endtask
`endif

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_adr_i   = '0;
        req_sel_i   = '0;
        req_dat_i   = '0;
        rsp_ready_i = 1'b0;
        wb_dat_i    = '0;
        slave_idle();
        repeat (2) step();
        check("reset_outputs", 32'({req_ready_o, rsp_valid_o, wb_cyc_o, wb_stb_o, rsp_err_o}), 32'd0);
        check("reset_wb_adr", 32'(wb_adr_o), 32'd0);
        rst_i = 1'b0;

        // Read, one stall cycle, ack on cycle 2
        run_txn(1'b0, AW'(4), 4'hF, 32'd0, 32'h15, 1, 2, 0, 0, 1'b0);
        // Write acked while still in the strobe cycle
        run_txn(1'b1, AW'(8), 4'hF, 32'h7, 32'hDEAD_BEEF, 0, 0, 0, 0, 1'b0);
        // No answer: timeout; unaligned address is forced aligned
        run_txn(1'b0, AW'(3), 4'h1, 32'd0, 32'h1234, 0, 0, 4, 0, 1'b0);
        // err and ack together
        run_txn(1'b0, AW'(12), 4'hF, 32'd0, 32'hAAAA_5555, 0, 1, 3, 0, 1'b0);
        // Response held three cycles with a new request pending
        run_txn(1'b0, AW'(4), 4'h3, 32'd0, 32'h0000_00C3, 2, 3, 0, 3, 1'b1);
        // Termination on the expiry cycle beats the timeout
        run_txn(1'b0, AW'(8), 4'hF, 32'd0, 32'h600D, 1, TMO, 0, 0, 1'b0);
        run_txn(1'b1, AW'(8), 4'hF, 32'h1, 32'h0, 0, TMO, 1, 0, 1'b0);
        // Termination one cycle too late loses to the timeout
        run_txn(1'b0, AW'(8), 4'hF, 32'd0, 32'h0BAD, 0, TMO + 1, 0, 0, 1'b0);
        // Termination while stall still asserted
        run_txn(1'b0, AW'(0), 4'hF, 32'd0, 32'h5A5A_0001, 3, 1, 0, 0, 1'b0);
        // rty (err in the default build)
        run_txn(1'b0, AW'(4), 4'hF, 32'd0, 32'h77, 0, 1, 2, 0, 1'b0);

        // Reset pulsed mid-transaction, in the wait phase
        issue(1'b0, AW'(4), 4'hF, 32'd0);
        step();
        check("in_wait", 32'({wb_cyc_o, wb_stb_o}), 32'd2);
        #2 rst_i = 1'b1;
        #1;
        check("async_reset_drop", 32'({wb_cyc_o, wb_stb_o, rsp_valid_o, req_ready_o}), 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        step();
        check("after_reset", 32'({req_ready_o, rsp_valid_o, wb_cyc_o}), 32'd4);

`ifdef WB_HOST_BRIDGE_RETRY_EN
        retry_txn(2, 32'h0000_0042);
        retry_txn(4, 32'h0000_0099);
`endif

        for (int n = 0; n < 150; n++) begin
            run_txn(1'($urandom), AW'($urandom), 4'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, TMO + 2)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_host_bridge.md
Name: wb_host_bridge

Overview:
- Wishbone pipelined master that sits directly upstream of the generated register-bank slaves and drives their wb_* port.
- Converts a simple valid/ready host request/response channel into single Wishbone cycles: one outstanding transaction, stall-aware strobe, bounded wait.
- Always returns a response: slave ack or err, or an internal timeout error when the slave never answers.

Parameters:
- ADDR_WIDTH, 4: byte-address width; req_adr_i and wb_adr_o both carry the byte address.
- TIMEOUT, 255: cycles from strobe start to forced error; legal range 2..65535.
- CNT_WIDTH, 16: timeout counter width; must satisfy TIMEOUT < 2**CNT_WIDTH.

Ports:
- clk_i in 1: clock.
- rst_i in 1: asynchronous, active-high reset.
- req_valid_i in 1: host request valid.
- req_ready_o out 1: bridge accepts the request this cycle.
- req_we_i in 1: 1 = write, 0 = read.
- req_adr_i in ADDR_WIDTH: byte address.
- req_sel_i in 4: byte lanes.
- req_dat_i in 32: write data.
- rsp_valid_o out 1: response valid.
- rsp_ready_i in 1: host consumes the response.
- rsp_dat_o out 32: read data; 0 for writes and errors.
- rsp_err_o out 1: slave err, rty or timeout.
- rsp_tmo_o out 1: error was caused by timeout.
- wb_cyc_o out 1: Wishbone cycle.
- wb_stb_o out 1: Wishbone strobe.
- wb_adr_o out ADDR_WIDTH: Wishbone address, bits [1:0] forced 0.
- wb_sel_o out 4: Wishbone byte select.
- wb_we_o out 1: Wishbone write enable.
- wb_dat_o out 32: Wishbone write data.
- wb_dat_i in 32: Wishbone read data.
- wb_ack_i in 1: Wishbone ack.
- wb_err_i in 1: Wishbone err.
- wb_rty_i in 1: Wishbone retry.
- wb_stall_i in 1: Wishbone stall.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counter 0.
- FSM states:
  - IDLE: req_ready_o = 1. On req_valid_i, register adr/sel/we/dat, clear counter, go to STROBE. Request-to-cyc/stb latency is 1 cycle.
  - STROBE: cyc = 1, stb = 1, address/data held stable.
    - ack, err or rty present → RESP. Termination is accepted even when wb_stall_i = 1, and regardless of stall when it coincides with stall release; the slave drops stall together with ack.
    - Else if wb_stall_i = 0 → WAIT (strobe issued once).
  - WAIT: cyc = 1, stb = 0. ack, err or rty → RESP.
  - Termination priority when several are present: err > rty > ack. Capture wb_dat_i only on an ack of a read.
  - RESP: cyc = 0, stb = 0; rsp_valid_o = 1 until the rsp_ready_i handshake, then IDLE. Next request is accepted no earlier than the cycle after the handshake.
- Timeout:
  - Counter increments every cycle in STROBE and WAIT.
  - When counter == TIMEOUT with no termination in that cycle → RESP with err = 1, tmo = 1, dat = 0; cyc/stb drop the next cycle.
  - Termination in the same cycle as expiry wins over the timeout.
- Terminations outside STROBE/WAIT are ignored.
- rsp_* are registered and stable while rsp_valid_o = 1 and not consumed.
- rst_i mid-transaction: cyc/stb drop immediately (asynchronous); any pending response is lost.

Optional Feature:
- Macro WB_HOST_BRIDGE_RETRY_EN.
- Defined: wb_rty_i re-issues the same access (back to STROBE, counter not cleared) up to 3 retries; the 4th rty reports err = 1, tmo = 0.
- Undefined: rty is treated as err immediately.

Decomposition:
- Package wb_host_bridge_pkg:
  - state enum (IDLE, STROBE, WAIT, RESP);
  - MAX_RETRY = 3;
  - response struct {dat, err, tmo}.
- Sub-module wb_host_bridge_tmo: loadable counter with expiry flag. Natural because the watchdog is reusable.

Test Plan:
- Read, slave stall 1 then ack on cycle 2 with wb_dat_i = 0x00000015 → single stb, rsp_dat_o = 0x00000015, err = 0, cyc low the cycle after ack.
- Write adr 0x8, dat 0x7, sel 0xF, slave acks in STROBE → wb_adr_o = 0x8, wb_dat_o = 0x7; rsp err = 0, dat = 0.
- No slave response, TIMEOUT = 4 → rsp_err_o = 1, rsp_tmo_o = 1 exactly 5 cycles after stb rises; cyc drops.
- err and ack asserted together → rsp_err_o = 1, rsp_dat_o = 0.
- rsp_ready_i held 0 for 3 cycles with a new req_valid_i pending → req_ready_o stays 0, rsp fields stable; request accepted after the handshake.
- rst_i pulsed during WAIT → cyc/stb/rsp_valid_o = 0 in that cycle; with the retry macro, 2 rty then ack → 3 strobes, err = 0.
